// File: rtl/cpu_bus_bridge_pkg.sv
// Shared encodings and lane helpers for the CPU-to-word-bus bridge.
package cpu_bus_bridge_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_RD,
        S_RMW_RD,
        S_RMW_WR,
        S_ACK
    } state_t;

    // Little-endian lane select, zero-extended; size 11 behaves as a word.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off);
        logic [31:0] v;
        v = word;
        if (size == SIZE_B) begin
            v = word >> {off, 3'b000};
            v = {24'd0, v[7:0]};
        end else if (size == SIZE_H) begin
            v = word >> {off[1], 4'b0000};
            v = {16'd0, v[15:0]};
        end
        return v;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] mask;
        logic [31:0] ins;
        mask = 32'hFFFF_FFFF;
        ins  = data;
        if (size == SIZE_B) begin
            mask = 32'h0000_00FF << {off, 3'b000};
            ins  = {24'd0, data[7:0]} << {off, 3'b000};
        end else if (size == SIZE_H) begin
            mask = 32'h0000_FFFF << {off[1], 4'b0000};
            ins  = {16'd0, data[15:0]} << {off[1], 4'b0000};
        end
        return (old & ~mask) | (ins & mask);
    endfunction

endpackage

// File: rtl/cpu_bus_bridge_wbuf.sv
// Posted write buffer: counter-based synchronous FIFO, any depth (0 = always full and empty).
module cpu_wbuf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 54
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    generate
        if (DEPTH == 0) begin : g_none
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, push, pop, push_data};
            assign full  = 1'b1;
            assign empty = 1'b1;
            assign head  = '0;
        end else begin : g_fifo
            localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
            localparam int CW = $clog2(DEPTH + 1);

            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [PW-1:0]    r_rd;
            logic [PW-1:0]    r_wr;
            logic [CW-1:0]    r_cnt;
            logic             w_push;
            logic             w_pop;

            assign full   = (r_cnt == CW'(DEPTH));
            assign empty  = (r_cnt == '0);
            assign head   = r_mem[r_rd];
            assign w_pop  = pop && !empty;
            // A full buffer still accepts a push when the head leaves in the same cycle.
            assign w_push = push && (!full || w_pop);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd  <= '0;
                    r_wr  <= '0;
                    r_cnt <= '0;
                end else begin
                    if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
                    if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
                    if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
                    else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (w_push) r_mem[r_wr] <= push_data;
            end
        end
    endgenerate

endmodule

// File: rtl/cpu_bus_bridge.sv
// Byte/halfword/word CPU accesses onto a 32-bit word bus: RMW for sub-word writes,
// posted word writes drained ahead of any read or RMW.
module cpu_bus_bridge #(
    parameter int ADDR_WIDTH = 24,
    parameter int WBUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_stb,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_size,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_dout,
    output logic [31:0]           cpu_din,
    output logic                  cpu_ack,
    output logic                  bus_stb,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-3:0] bus_addr,
    input  logic [31:0]           bus_din,
    output logic [31:0]           bus_dout,
    input  logic                  bus_ack
);
    import cpu_bus_bridge_pkg::*;

    localparam int WA = ADDR_WIDTH - 2;
    localparam int EW = WA + 32;

    state_t          r_state, w_next;
    logic [31:0]     r_din, r_merge, r_dout;
    logic            r_stb, r_we, r_drain_busy;
    logic [WA-1:0]   r_addr;
    logic            w_full, w_empty, w_push, w_pop;
    logic            w_fsm_go, w_go_we, w_drain_go, w_bus_done, w_word, w_fsm_owns;
    logic [31:0]     w_go_data;
    logic [EW-1:0]   w_head;
    logic [WA-1:0]   w_waddr;

    assign w_word     = cpu_size[1];
    assign w_waddr    = cpu_addr[ADDR_WIDTH-1:2];
    assign w_bus_done = r_stb && bus_ack;
    assign w_pop      = r_drain_busy && bus_ack;
    assign w_fsm_owns = (r_state == S_RD) || (r_state == S_RMW_RD) || (r_state == S_RMW_WR);
    assign w_drain_go = !r_stb && !w_empty && !w_fsm_go && !w_fsm_owns;

    cpu_wbuf #(.DEPTH(WBUF_DEPTH), .WIDTH(EW)) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data ({w_waddr, cpu_dout}),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // Transitions into RD/RMW_RD launch the strobe on the same edge to save a cycle.
    always_comb begin
        w_next    = r_state;
        w_push    = 1'b0;
        w_fsm_go  = 1'b0;
        w_go_we   = 1'b0;
        w_go_data = r_merge;
        case (r_state)
            S_IDLE: if (cpu_stb) begin
                if (cpu_we && w_word) begin
                    if (WBUF_DEPTH > 0) begin
                        if (!w_full || w_pop) begin
                            w_push = 1'b1;
                            w_next = S_ACK;
                        end
                    end else begin
                        w_next    = S_RMW_WR;
                        w_fsm_go  = 1'b1;
                        w_go_we   = 1'b1;
                        w_go_data = cpu_dout;
                    end
                end else if (!w_empty) begin
                    w_next = S_DRAIN;
                end else begin
                    w_next   = cpu_we ? S_RMW_RD : S_RD;
                    w_fsm_go = 1'b1;
                end
            end
            S_DRAIN: if (w_empty) begin
                w_next   = cpu_we ? S_RMW_RD : S_RD;
                w_fsm_go = 1'b1;
            end
            S_RD:     if (w_bus_done) w_next = S_ACK;
            S_RMW_RD: if (w_bus_done) w_next = S_RMW_WR;
            S_RMW_WR: begin
                if (!r_stb) begin
                    w_fsm_go = 1'b1;
                    w_go_we  = 1'b1;
                end else if (bus_ack) begin
                    w_next = S_ACK;
                end
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_din   <= '0;
            r_merge <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_RD && w_bus_done)
                r_din <= lane_extract(bus_din, cpu_size, cpu_addr[1:0]);
            if (r_state == S_RMW_RD && w_bus_done)
                r_merge <= lane_merge(bus_din, cpu_dout, cpu_size, cpu_addr[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_dout       <= '0;
            r_drain_busy <= 1'b0;
        end else if (w_bus_done) begin
            r_stb        <= 1'b0;
            r_drain_busy <= 1'b0;
        end else if (w_fsm_go) begin
            r_stb  <= 1'b1;
            r_we   <= w_go_we;
            r_addr <= w_waddr;
            r_dout <= w_go_data;
        end else if (w_drain_go) begin
            r_stb        <= 1'b1;
            r_we         <= 1'b1;
            r_addr       <= w_head[EW-1:32];
            r_dout       <= w_head[31:0];
            r_drain_busy <= 1'b1;
        end
    end

    assign cpu_din  = r_din;
    assign cpu_ack  = (r_state == S_ACK);
    assign bus_stb  = r_stb;
    assign bus_we   = r_we;
    assign bus_addr = r_addr;
    assign bus_dout = r_dout;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed and randomized checks of cpu_bus_bridge against a byte-level memory model.
module tb_cpu_bus_bridge;

    typedef struct {
        logic        we;
        logic [21:0] addr;
        logic [31:0] data;
        int          start;
        int          ackc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic        cpu_stb = 1'b0, cpu_we = 1'b0;
    logic [1:0]  cpu_size = 2'b00;
    logic [23:0] cpu_addr = '0;
    logic [31:0] cpu_dout = '0;
    logic [31:0] cpu_din;
    logic        cpu_ack;
    logic        bus_stb, bus_we;
    logic [21:0] bus_addr;
    logic [31:0] bus_dout;
    logic [31:0] bus_din = '0;
    logic        bus_ack = 1'b0;

    logic        c0_stb = 1'b0, c0_we = 1'b0;
    logic [1:0]  c0_size = 2'b00;
    logic [23:0] c0_addr = '0;
    logic [31:0] c0_dout = '0;
    logic [31:0] c0_din;
    logic        c0_ack;
    logic        b0_stb, b0_we;
    logic [21:0] b0_addr;
    logic [31:0] b0_dout;
    logic [31:0] b0_din = '0;
    logic        b0_ack = 1'b0;

    cpu_bus_bridge #(.ADDR_WIDTH(24), .WBUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
        .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_din(bus_din),
        .bus_dout(bus_dout), .bus_ack(bus_ack)
    );

    cpu_bus_bridge #(.ADDR_WIDTH(24), .WBUF_DEPTH(0)) dut0 (
        .clk(clk), .rst(rst), .cpu_stb(c0_stb), .cpu_we(c0_we), .cpu_size(c0_size),
        .cpu_addr(c0_addr), .cpu_dout(c0_dout), .cpu_din(c0_din), .cpu_ack(c0_ack),
        .bus_stb(b0_stb), .bus_we(b0_we), .bus_addr(b0_addr), .bus_din(b0_din),
        .bus_dout(b0_dout), .bus_ack(b0_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word-bus slave: wait states per transaction (ws_cfg<0 = random 0..3), optional write hold.
    logic [31:0] mem [int];
    txn_t        log_q[$];
    int          ws_cfg = 0, ws_cnt = 0, txn_start = 0;
    bit          hold_wr = 1'b0, in_txn = 1'b0;

    always @(negedge clk) begin
        if (bus_ack) begin
            bus_ack = 1'b0;
        end else if (bus_stb) begin
            if (!in_txn) begin
                in_txn    = 1'b1;
                txn_start = cyc;
                ws_cnt    = (ws_cfg < 0) ? int'($urandom_range(3, 0)) : ws_cfg;
            end
            if (ws_cnt > 0) begin
                ws_cnt--;
            end else if (!(hold_wr && bus_we)) begin
                bus_ack = 1'b1;
                in_txn  = 1'b0;
                if (bus_we) mem[int'(bus_addr)] = bus_dout;
                else bus_din = mem.exists(int'(bus_addr)) ? mem[int'(bus_addr)] : 32'd0;
                log_q.push_back('{bus_we, bus_addr, bus_we ? bus_dout : bus_din, txn_start, cyc});
            end
        end else begin
            in_txn = 1'b0;
        end
    end

    int          ws0 = 3, cnt0 = 0, b0_ackc = -1, b0_n = 0, b0_rds = 0;
    bit          in0 = 1'b0;
    logic [31:0] b0_wdata = '0;
    logic [21:0] b0_waddr = '0;

    always @(negedge clk) begin
        if (b0_ack) begin
            b0_ack = 1'b0;
        end else if (b0_stb) begin
            if (!in0) begin
                in0  = 1'b1;
                cnt0 = ws0;
            end
            if (cnt0 > 0) begin
                cnt0--;
            end else begin
                b0_ack  = 1'b1;
                in0     = 1'b0;
                b0_ackc = cyc;
                b0_n++;
                if (b0_we) begin
                    b0_wdata = b0_dout;
                    b0_waddr = b0_addr;
                end else begin
                    b0_rds++;
                end
            end
        end else begin
            in0 = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+#1; that cycle is cycle 0 of the request. lat = cycle of cpu_ack.
    task automatic cpu_op(input logic we, input logic [1:0] size, input logic [23:0] addr,
                          input logic [31:0] data, output logic [31:0] rd, output int lat,
                          output int ackc);
        bit got;
        cpu_stb = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_dout = data;
        got = 1'b0; lat = -1; ackc = -1; rd = '0;
        for (int n = 1; n <= 200 && !got; n++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin
                got = 1'b1; lat = n; ackc = cyc; rd = cpu_din;
            end
        end
        cpu_stb = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        chk("ack_one_cycle", 32'(cpu_ack), 32'd0);
    endtask

    logic [7:0]  refb [64];
    logic [31:0] rd, expv, v;
    int          lat, ackc, n0, n1;
    logic        rwe;
    logic [1:0]  rsz;
    int          off, base, nb;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cpu_din", cpu_din, 32'd0);
        chk("rst_bus_stb", 32'(bus_stb), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_dout", bus_dout, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Byte read from the top lane
        mem[0] = 32'hA1B2C3D4; ws_cfg = 0;
        cpu_op(1'b0, 2'b00, 24'h000003, 32'd0, rd, lat, ackc);
        chk("rdb_data", rd, 32'h000000A1);
        chk("rdb_lat", 32'(lat), 32'd2);
        chk("rdb_addr", 32'(log_q[$].addr), 32'd0);

        // Halfword RMW into the upper lane
        mem[32'h40] = 32'h11223344;
        n0 = log_q.size();
        cpu_op(1'b1, 2'b01, 24'h000102, 32'h0000BEEF, rd, lat, ackc);
        chk("rmw_lat", 32'(lat), 32'd4);
        chk("rmw_ntxn", 32'(log_q.size() - n0), 32'd2);
        if (log_q.size() >= n0 + 2) begin
            chk("rmw_rd_we", 32'(log_q[n0].we), 32'd0);
            chk("rmw_rd_addr", 32'(log_q[n0].addr), 32'h40);
            chk("rmw_wr_addr", 32'(log_q[n0+1].addr), 32'h40);
            chk("rmw_wr_data", log_q[n0+1].data, 32'hBEEF3344);
        end
        chk("din_held", cpu_din, 32'h000000A1);

        // Buffer full stall with writes held on the bus
        hold_wr = 1'b1; ws_cfg = 0;
        n0 = log_q.size();
        cpu_op(1'b1, 2'b10, 24'h000300, 32'hAAAA0001, rd, lat, ackc);
        chk("wb1_lat", 32'(lat), 32'd1);
        cpu_op(1'b1, 2'b11, 24'h000305, 32'hAAAA0002, rd, lat, ackc);
        chk("wb2_lat", 32'(lat), 32'd1);
        fork
            cpu_op(1'b1, 2'b10, 24'h000308, 32'hAAAA0003, rd, lat, ackc);
            begin
                repeat (6) @(posedge clk);
                #1 hold_wr = 1'b0;
            end
        join
        chk("wb3_stalled", 32'(lat > 4), 32'd1);
        chk("wb3_first_done", 32'(log_q.size() > n0), 32'd1);
        if (log_q.size() > n0) chk("wb3_ack_after_pop", 32'(ackc), 32'(log_q[n0].ackc + 1));
        repeat (20) @(posedge clk);
        #1;
        chk("wb_order", 32'(log_q.size() - n0), 32'd3);
        if (log_q.size() >= n0 + 3) begin
            chk("wb_order0", 32'(log_q[n0].addr), 32'hC0);
            chk("wb_order1", 32'(log_q[n0+1].addr), 32'hC1);
            chk("wb_order2", 32'(log_q[n0+2].addr), 32'hC2);
        end
        chk("wb_mem1", mem[32'hC1], 32'hAAAA0002);
        chk("wb_mem2", mem[32'hC2], 32'hAAAA0003);

        // Read ordered behind a posted write
        ws_cfg = 3;
        cpu_op(1'b1, 2'b10, 24'h000010, 32'hCAFEBABE, rd, lat, ackc);
        chk("pw_lat", 32'(lat), 32'd1);
        n1 = log_q.size();
        cpu_op(1'b0, 2'b10, 24'h000010, 32'd0, rd, lat, ackc);
        chk("pw_rd_data", rd, 32'hCAFEBABE);
        chk("pw_ntxn", 32'(log_q.size() - n1), 32'd2);
        if (log_q.size() >= n1 + 2) begin
            chk("pw_first_is_wr", 32'(log_q[n1].we), 32'd1);
            chk("pw_rd_after_wr", 32'(log_q[n1+1].start > log_q[n1].ackc), 32'd1);
        end

        // Reset while RMW_WR holds the bus
        ws_cfg = 0; hold_wr = 1'b1; mem[32'h41] = 32'h0A0B0C0D;
        cpu_stb = 1'b1; cpu_we = 1'b1; cpu_size = 2'b01; cpu_addr = 24'h000104; cpu_dout = 32'h5555;
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(posedge clk); #1;
                if (bus_stb && bus_we) seen = 1'b1;
            end
            chk("rst_wr_seen", 32'(seen), 32'd1);
        end
        rst = 1'b1; cpu_stb = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_stb", 32'(bus_stb), 32'd0);
        chk("rst_mid_ack", 32'(cpu_ack), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_mem", mem[32'h41], 32'h0A0B0C0D);

        // Reset discards posted writes
        mem[32'h80] = 32'h80808080; mem[32'h81] = 32'h81818181;
        cpu_op(1'b1, 2'b10, 24'h000200, 32'h11111111, rd, lat, ackc);
        cpu_op(1'b1, 2'b10, 24'h000204, 32'h22222222, rd, lat, ackc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; hold_wr = 1'b0;
        n0 = log_q.size();
        repeat (10) @(posedge clk);
        #1;
        chk("rst_buf_no_txn", 32'(log_q.size() - n0), 32'd0);
        cpu_op(1'b0, 2'b10, 24'h000200, 32'd0, rd, lat, ackc);
        chk("rst_buf_rd_lat", 32'(lat), 32'd2);
        chk("rst_buf_rd_data", rd, 32'h80808080);
        chk("rst_buf_mem81", mem[32'h81], 32'h81818181);

        // Randomized traffic against a byte-addressed model of words 0x100..0x10F
        for (int w = 0; w < 16; w++) begin
            v = $urandom;
            mem[32'h100 + w] = v;
            for (int b = 0; b < 4; b++) refb[w*4 + b] = v[8*b +: 8];
        end
        ws_cfg = -1;
        for (int t = 0; t < 200; t++) begin
            rwe  = 1'(($urandom_range(1, 0)));
            rsz  = 2'($urandom_range(3, 0));
            off  = int'($urandom_range(63, 0));
            v    = $urandom;
            nb   = (rsz == 2'b00) ? 1 : (rsz == 2'b01) ? 2 : 4;
            base = off - (off % nb);
            cpu_op(rwe, rsz, 24'h000400 + 24'(off), v, rd, lat, ackc);
            if (rwe) begin
                for (int b = 0; b < nb; b++) refb[base + b] = v[8*b +: 8];
            end else begin
                expv = '0;
                for (int b = 0; b < nb; b++) expv[8*b +: 8] = refb[base + b];
                chk($sformatf("rand_rd_%0d", t), rd, expv);
            end
        end
        for (int w = 0; w < 16; w++) begin
            cpu_op(1'b0, 2'b10, 24'h000400 + 24'(w*4), 32'd0, rd, lat, ackc);
            expv = {refb[w*4+3], refb[w*4+2], refb[w*4+1], refb[w*4]};
            chk($sformatf("final_word_%0d", w), rd, expv);
        end

        // Unbuffered word write (WBUF_DEPTH=0) with three wait states
        ws0 = 3;
        c0_stb = 1'b1; c0_we = 1'b1; c0_size = 2'b10; c0_addr = 24'h000008; c0_dout = 32'h12345678;
        begin
            bit got0;
            int ack0;
            got0 = 1'b0; ack0 = -1;
            for (int n = 0; n < 50 && !got0; n++) begin
                @(posedge clk); #1;
                if (c0_ack) begin
                    got0 = 1'b1; ack0 = cyc;
                end
            end
            c0_stb = 1'b0;
            chk("d0_ack_seen", 32'(got0), 32'd1);
            chk("d0_ack_timing", 32'(ack0), 32'(b0_ackc + 1));
        end
        chk("d0_wdata", b0_wdata, 32'h12345678);
        chk("d0_waddr", 32'(b0_waddr), 32'd2);
        chk("d0_no_read", 32'(b0_rds), 32'd0);
        chk("d0_one_txn", 32'(b0_n), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
